// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the round-robin arbiter, its requesters and the channel Mux.
// The arbiter takes the master view; requesters and the Mux take the slave view.
interface rr_arbiter_if #(
    parameter int CHANNELS = 4
);
    localparam int ADDR_SIZE = $clog2(CHANNELS);

    logic [CHANNELS-1:0]  req;
    logic [CHANNELS-1:0]  grant;
    logic [ADDR_SIZE-1:0] sel;
    logic                 enable;

    modport master (
        input  req,
        output grant,
        output sel,
        output enable
    );

    modport slave (
        output req,
        input  grant,
        input  sel,
        input  enable
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter feeding the channel Mux: registered one-hot grant, sel and enable,
// with a hold limit that forces hand-over when another channel is waiting.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter_if.master  bus
);
    localparam int ADDR_SIZE = $clog2(CHANNELS);
    localparam int HOLD_SAT  = (MAX_HOLD == 0) ? 1 : MAX_HOLD;
    localparam int HCNT_W    = $clog2(HOLD_SAT + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state_r,  state_s;
    logic [ADDR_SIZE-1:0]  ptr_r,    ptr_s;
    logic [HCNT_W-1:0]     hcnt_r,   hcnt_s;
    logic [CHANNELS-1:0]   grant_r,  grant_s;
    logic [ADDR_SIZE-1:0]  sel_r,    sel_s;
    logic                  enable_r, enable_s;

    logic [CHANNELS-1:0]   cur_oh_s;
    logic [CHANNELS-1:0]   others_s;
    logic                  rel_a_s;
    logic                  rel_b_s;
    logic [ADDR_SIZE-1:0]  ptr_inc_s;
    logic [ADDR_SIZE:0]    win_s;

    function automatic logic [CHANNELS-1:0] onehot(input logic [ADDR_SIZE-1:0] idx);
        logic [CHANNELS-1:0] v;
        v = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            v[i] = (idx == ADDR_SIZE'(i));
        end
        return v;
    endfunction

    // Returns {found, index}: first set request scanning cyclically from p.
    function automatic logic [ADDR_SIZE:0] search(input logic [CHANNELS-1:0]  r,
                                                  input logic [ADDR_SIZE-1:0] p);
        logic [2*CHANNELS-1:0] dbl;
        logic [CHANNELS-1:0]   rot;
        logic                  found;
        logic [ADDR_SIZE-1:0]  win;
        int                    pos;
        dbl   = {r, r} >> p;
        rot   = dbl[CHANNELS-1:0];
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                pos   = int'(p) + i;
                if (pos >= CHANNELS) begin
                    pos = pos - CHANNELS;
                end else begin
                    pos = pos;
                end
                win = ADDR_SIZE'(pos);
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    // Release decode for the channel currently holding the grant.
    always_comb begin
        cur_oh_s  = onehot(sel_r);
        others_s  = bus.req & ~cur_oh_s;
        rel_a_s   = ((bus.req & cur_oh_s) == '0);
        rel_b_s   = (MAX_HOLD != 0) && (hcnt_r == HCNT_W'(MAX_HOLD)) && (others_s != '0);
        if (sel_r == ADDR_SIZE'(CHANNELS - 1)) begin
            ptr_inc_s = '0;
        end else begin
            ptr_inc_s = sel_r + ADDR_SIZE'(1);
        end
    end

    // Next-state and next-output logic; all three outputs are updated together.
    always_comb begin
        state_s  = state_r;
        ptr_s    = ptr_r;
        hcnt_s   = hcnt_r;
        grant_s  = grant_r;
        sel_s    = sel_r;
        enable_s = enable_r;
        win_s    = '0;
        case (state_r)
            IDLE: begin
                win_s = search(bus.req, ptr_r);
                if (win_s[ADDR_SIZE]) begin
                    state_s  = GRANT;
                    grant_s  = onehot(win_s[ADDR_SIZE-1:0]);
                    sel_s    = win_s[ADDR_SIZE-1:0];
                    enable_s = 1'b1;
                    hcnt_s   = HCNT_W'(1);
                end else begin
                    grant_s  = '0;
                    sel_s    = '0;
                    enable_s = 1'b0;
                    hcnt_s   = '0;
                end
            end
            GRANT: begin
                if (rel_a_s || rel_b_s) begin
                    // The releasing channel is masked so a forced hand-over cannot re-pick it.
                    ptr_s = ptr_inc_s;
                    win_s = search(others_s, ptr_inc_s);
                    if (win_s[ADDR_SIZE]) begin
                        grant_s  = onehot(win_s[ADDR_SIZE-1:0]);
                        sel_s    = win_s[ADDR_SIZE-1:0];
                        enable_s = 1'b1;
                        hcnt_s   = HCNT_W'(1);
                    end else begin
                        state_s  = IDLE;
                        grant_s  = '0;
                        sel_s    = '0;
                        enable_s = 1'b0;
                        hcnt_s   = '0;
                    end
                end else if (hcnt_r < HCNT_W'(HOLD_SAT)) begin
                    hcnt_s = hcnt_r + HCNT_W'(1);
                end else begin
                    hcnt_s = hcnt_r;
                end
            end
            default: begin
                state_s  = IDLE;
                ptr_s    = '0;
                hcnt_s   = '0;
                grant_s  = '0;
                sel_s    = '0;
                enable_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            ptr_r    <= '0;
            hcnt_r   <= '0;
            grant_r  <= '0;
            sel_r    <= '0;
            enable_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            ptr_r    <= ptr_s;
            hcnt_r   <= hcnt_s;
            grant_r  <= grant_s;
            sel_r    <= sel_s;
            enable_r <= enable_s;
        end
    end

    assign bus.grant  = grant_r;
    assign bus.sel    = sel_r;
    assign bus.enable = enable_r;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed-vector bench for rr_arbiter (CHANNELS=4, MAX_HOLD=3): the driver pushes the
// hand-computed response for each edge into a queue; a monitor pops and compares.
module tb_rr_arbiter;
    logic clk;
    logic rst;

    rr_arbiter_if #(.CHANNELS(4)) arb ();

    rr_arbiter #(
        .CHANNELS (4),
        .MAX_HOLD (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (arb)
    );

    typedef struct {
        int         idx;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       en;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   vec_no;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector, and after the edge queue the response expected from it.
    task automatic step(input logic r, input logic [3:0] rq, input logic e, input logic [1:0] s);
        exp_t x;
        rst     = r;
        arb.req = rq;
        @(posedge clk);
        #1;
        x.idx   = vec_no;
        x.en    = e;
        x.sel   = e ? s : 2'd0;
        x.grant = e ? (4'b0001 << s) : 4'b0000;
        exp_q.push_back(x);
        vec_no++;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_checks++;
            if (arb.grant !== x.grant || arb.sel !== x.sel || arb.enable !== x.en) begin
                n_fail++;
                $display("FAIL vec%0d: got grant=%b sel=%0d enable=%b, want grant=%b sel=%0d enable=%b",
                         x.idx, arb.grant, arb.sel, arb.enable, x.grant, x.sel, x.en);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vec_no   = 0;
        rst      = 1'b1;
        arb.req  = 4'b0000;

        // reset held two cycles with every channel requesting
        step(1'b1, 4'b1111, 1'b0, 2'd0);
        step(1'b1, 4'b1111, 1'b0, 2'd0);

        // rotation with hold limit 3: 0,0,0,1,1,1,2,2,2,3,3,3,0
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 4'b1111, 1'b1, 2'((i / 3) % 4));
        end
        step(1'b0, 4'b0000, 1'b0, 2'd0);

        // voluntary release of channel 2, then ptr=3 makes channel 3 win
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0100, 1'b1, 2'd2);
        end
        step(1'b0, 4'b0000, 1'b0, 2'd0);
        step(1'b0, 4'b1111, 1'b1, 2'd3);
        step(1'b0, 4'b0000, 1'b0, 2'd0);

        // sole requester never preempted; saturated hold then hands over to channel 3
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0010, 1'b1, 2'd1);
        end
        step(1'b0, 4'b1010, 1'b1, 2'd3);
        step(1'b0, 4'b0000, 1'b0, 2'd0);

        // wrap and skip: channel 1 releases (ptr=2), then 3, then wrap to 0
        step(1'b0, 4'b0010, 1'b1, 2'd1);
        step(1'b0, 4'b0000, 1'b0, 2'd0);
        step(1'b0, 4'b1001, 1'b1, 2'd3);
        step(1'b0, 4'b1001, 1'b1, 2'd3);
        step(1'b0, 4'b0001, 1'b1, 2'd0);
        step(1'b0, 4'b0100, 1'b1, 2'd2);
        step(1'b0, 4'b0000, 1'b0, 2'd0);

        // mid-grant reset with ptr=3; afterwards the search restarts at channel 0
        step(1'b0, 4'b0100, 1'b1, 2'd2);
        step(1'b0, 4'b1100, 1'b1, 2'd2);
        step(1'b1, 4'b1100, 1'b0, 2'd0);
        step(1'b0, 4'b1100, 1'b1, 2'd2);
        step(1'b0, 4'b1100, 1'b1, 2'd2);
        step(1'b0, 4'b1100, 1'b1, 2'd2);
        step(1'b0, 4'b1100, 1'b1, 2'd3);
        step(1'b0, 4'b1100, 1'b1, 2'd3);
        step(1'b0, 4'b1100, 1'b1, 2'd3);
        step(1'b0, 4'b1100, 1'b1, 2'd2);
        step(1'b0, 4'b0000, 1'b0, 2'd0);

        repeat (4) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked responses, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
